// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - DataPath control bundle between control_sequencer and DataPath
interface control_sequencer_if;
    logic [31:0] IR;
    logic        CON_FF;
    logic        Run;
    logic        PC_out, ZHigh_out, ZLow_out, HI_out, LO_out, C_out, MDR_out, in_port_out;
    logic        MAR_enable, MDR_enable, IR_enable, Y_enable, Z_enable, PC_enable;
    logic        HI_enable, LO_enable, out_port_enable;
    logic        IncPC, Read, RAM_write_enable, con_in;
    logic        Gra, Grb, Grc, R_in, R_out, BA_out;
    logic [4:0]  opcode;

    modport master (
        input  IR, CON_FF,
        output Run,
        output PC_out, ZHigh_out, ZLow_out, HI_out, LO_out, C_out, MDR_out, in_port_out,
        output MAR_enable, MDR_enable, IR_enable, Y_enable, Z_enable, PC_enable,
        output HI_enable, LO_enable, out_port_enable,
        output IncPC, Read, RAM_write_enable, con_in,
        output Gra, Grb, Grc, R_in, R_out, BA_out,
        output opcode
    );

    modport slave (
        output IR, CON_FF,
        input  Run,
        input  PC_out, ZHigh_out, ZLow_out, HI_out, LO_out, C_out, MDR_out, in_port_out,
        input  MAR_enable, MDR_enable, IR_enable, Y_enable, Z_enable, PC_enable,
        input  HI_enable, LO_enable, out_port_enable,
        input  IncPC, Read, RAM_write_enable, con_in,
        input  Gra, Grb, Grc, R_in, R_out, BA_out,
        input  opcode
    );
endinterface

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hard-wired T0-T7 step sequencer driving the DataPath controls
// Optional mul/div execute sequences are enabled by defining CTRL_MULDIV_EN.
module control_sequencer #(
    parameter logic [4:0] OP_ADD = 5'b00011
) (
    input  logic                 Clock,
    input  logic                 clr,
    control_sequencer_if.master  bus
);
`ifdef CTRL_MULDIV_EN
    localparam bit MULDIV_EN = 1'b1;
`else
    localparam bit MULDIV_EN = 1'b0;
`endif

    typedef enum logic [3:0] {RESET, T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;
    typedef enum logic [3:0] {C_ALU, C_IMM, C_LDI, C_LD, C_ST, C_NEG, C_BR, C_MFHI, C_MFLO,
                              C_IN, C_OUT, C_HALT, C_MULDIV, C_NOP} cls_t;

    state_t     state;
    state_t     last_step;
    cls_t       cls;
    logic [4:0] op;
    logic       unused_ir;

    assign op        = bus.IR[31:27];
    assign unused_ir = ^bus.IR[26:0];

    always_comb begin
        cls = C_NOP;
        if (op >= 5'd3 && op <= 5'd11)
            cls = C_ALU;
        else if (op >= 5'd12 && op <= 5'd14)
            cls = C_IMM;
        else if (MULDIV_EN && (op == 5'b10000 || op == 5'b01111))
            cls = C_MULDIV;
        else begin
            case (op)
                5'b00000:           cls = C_LD;
                5'b00001:           cls = C_LDI;
                5'b00010:           cls = C_ST;
                5'b10001, 5'b10010: cls = C_NEG;
                5'b10011:           cls = C_BR;
                5'b10110:           cls = C_IN;
                5'b10111:           cls = C_OUT;
                5'b11000:           cls = C_MFHI;
                5'b11001:           cls = C_MFLO;
                5'b11011:           cls = C_HALT;
                default:            cls = C_NOP;
            endcase
        end
    end

    always_comb begin
        case (cls)
            C_ALU, C_IMM, C_LDI: last_step = T5;
            C_LD, C_ST:          last_step = T7;
            C_BR, C_MULDIV:      last_step = T6;
            C_NEG:               last_step = T4;
            default:             last_step = T3;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (clr)
            state <= RESET;
        else begin
            case (state)
                RESET:   state <= T0;
                T0:      state <= T1;
                T1:      state <= T2;
                T2:      state <= T3;
                HALT:    state <= HALT;
                default: begin
                    if (state == T3 && cls == C_HALT)
                        state <= HALT;
                    else if (state == last_step || state == T7)
                        state <= T0;
                    else
                        state <= state_t'(state + 4'd1);
                end
            endcase
        end
    end

    always_comb begin
        bus.Run = (state != RESET) && (state != HALT);
        bus.PC_out = 1'b0;      bus.ZHigh_out = 1'b0;   bus.ZLow_out = 1'b0;
        bus.HI_out = 1'b0;      bus.LO_out = 1'b0;      bus.C_out = 1'b0;
        bus.MDR_out = 1'b0;     bus.in_port_out = 1'b0;
        bus.MAR_enable = 1'b0;  bus.MDR_enable = 1'b0;  bus.IR_enable = 1'b0;
        bus.Y_enable = 1'b0;    bus.Z_enable = 1'b0;    bus.PC_enable = 1'b0;
        bus.HI_enable = 1'b0;   bus.LO_enable = 1'b0;   bus.out_port_enable = 1'b0;
        bus.IncPC = 1'b0;       bus.Read = 1'b0;        bus.RAM_write_enable = 1'b0;
        bus.con_in = 1'b0;
        bus.Gra = 1'b0;  bus.Grb = 1'b0;  bus.Grc = 1'b0;
        bus.R_in = 1'b0; bus.R_out = 1'b0; bus.BA_out = 1'b0;
        bus.opcode = 5'b00000;
        case (state)
            T0: begin bus.PC_out = 1'b1; bus.MAR_enable = 1'b1; end
            T1: begin bus.Read = 1'b1; bus.MDR_enable = 1'b1; bus.IncPC = 1'b1; bus.PC_enable = 1'b1; end
            T2: begin bus.MDR_out = 1'b1; bus.IR_enable = 1'b1; end
            T3, T4, T5, T6, T7: begin
                case (cls)
                    C_ALU, C_IMM: case (state)
                        T3: begin bus.Grb = 1'b1; bus.R_out = 1'b1; bus.Y_enable = 1'b1; end
                        T4: begin
                            bus.Grc = (cls == C_ALU); bus.R_out = (cls == C_ALU);
                            bus.C_out = (cls == C_IMM);
                            bus.opcode = op; bus.Z_enable = 1'b1;
                        end
                        T5: begin bus.ZLow_out = 1'b1; bus.Gra = 1'b1; bus.R_in = 1'b1; end
                        default: ;
                    endcase
                    // ldi, ld and st share the base+offset address computation in T3-T4
                    C_LDI, C_LD, C_ST: case (state)
                        T3: begin bus.Grb = 1'b1; bus.BA_out = 1'b1; bus.Y_enable = 1'b1; end
                        T4: begin bus.C_out = 1'b1; bus.opcode = OP_ADD; bus.Z_enable = 1'b1; end
                        T5: begin
                            bus.ZLow_out = 1'b1;
                            bus.Gra = (cls == C_LDI); bus.R_in = (cls == C_LDI);
                            bus.MAR_enable = (cls != C_LDI);
                        end
                        T6: begin
                            bus.MDR_enable = 1'b1;
                            bus.Read = (cls == C_LD);
                            bus.Gra = (cls == C_ST); bus.R_out = (cls == C_ST);
                        end
                        T7: begin
                            bus.MDR_out = (cls == C_LD); bus.Gra = (cls == C_LD); bus.R_in = (cls == C_LD);
                            bus.RAM_write_enable = (cls == C_ST);
                        end
                        default: ;
                    endcase
                    C_NEG: case (state)
                        T3: begin bus.Grb = 1'b1; bus.R_out = 1'b1; bus.opcode = op; bus.Z_enable = 1'b1; end
                        T4: begin bus.ZLow_out = 1'b1; bus.Gra = 1'b1; bus.R_in = 1'b1; end
                        default: ;
                    endcase
                    C_BR: case (state)
                        T3: begin bus.Gra = 1'b1; bus.R_out = 1'b1; bus.con_in = 1'b1; end
                        T4: begin bus.PC_out = 1'b1; bus.Y_enable = 1'b1; end
                        T5: begin bus.C_out = 1'b1; bus.opcode = OP_ADD; bus.Z_enable = 1'b1; end
                        T6: begin bus.ZLow_out = 1'b1; bus.PC_enable = bus.CON_FF; end
                        default: ;
                    endcase
                    C_MULDIV: case (state)
                        T3: begin bus.Gra = 1'b1; bus.R_out = 1'b1; bus.Y_enable = 1'b1; end
                        T4: begin bus.Grb = 1'b1; bus.R_out = 1'b1; bus.opcode = op; bus.Z_enable = 1'b1; end
                        T5: begin bus.ZLow_out = 1'b1; bus.LO_enable = 1'b1; end
                        T6: begin bus.ZHigh_out = 1'b1; bus.HI_enable = 1'b1; end
                        default: ;
                    endcase
                    C_MFHI: if (state == T3) begin bus.HI_out = 1'b1; bus.Gra = 1'b1; bus.R_in = 1'b1; end
                    C_MFLO: if (state == T3) begin bus.LO_out = 1'b1; bus.Gra = 1'b1; bus.R_in = 1'b1; end
                    C_IN:   if (state == T3) begin bus.in_port_out = 1'b1; bus.Gra = 1'b1; bus.R_in = 1'b1; end
                    C_OUT:  if (state == T3) begin bus.Gra = 1'b1; bus.R_out = 1'b1; bus.out_port_enable = 1'b1; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed-vector bench for control_sequencer
module tb_control_sequencer;
    logic Clock = 1'b0;
    logic clr   = 1'b1;

    control_sequencer_if bus();

    control_sequencer #(.OP_ADD(5'b00011)) dut (
        .Clock (Clock),
        .clr   (clr),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    localparam logic [32:0] B_RUN   = 33'd1 << 32;
    localparam logic [32:0] B_PCO   = 33'd1 << 31;
    localparam logic [32:0] B_ZHI   = 33'd1 << 30;
    localparam logic [32:0] B_ZLO   = 33'd1 << 29;
    localparam logic [32:0] B_HIO   = 33'd1 << 28;
    localparam logic [32:0] B_LOO   = 33'd1 << 27;
    localparam logic [32:0] B_CO    = 33'd1 << 26;
    localparam logic [32:0] B_MDRO  = 33'd1 << 25;
    localparam logic [32:0] B_INP   = 33'd1 << 24;
    localparam logic [32:0] B_MAR   = 33'd1 << 23;
    localparam logic [32:0] B_MDR   = 33'd1 << 22;
    localparam logic [32:0] B_IR    = 33'd1 << 21;
    localparam logic [32:0] B_Y     = 33'd1 << 20;
    localparam logic [32:0] B_Z     = 33'd1 << 19;
    localparam logic [32:0] B_PCE   = 33'd1 << 18;
    localparam logic [32:0] B_HIE   = 33'd1 << 17;
    localparam logic [32:0] B_LOE   = 33'd1 << 16;
    localparam logic [32:0] B_OUTP  = 33'd1 << 15;
    localparam logic [32:0] B_INC   = 33'd1 << 14;
    localparam logic [32:0] B_RD    = 33'd1 << 13;
    localparam logic [32:0] B_WR    = 33'd1 << 12;
    localparam logic [32:0] B_CON   = 33'd1 << 11;
    localparam logic [32:0] B_GRA   = 33'd1 << 10;
    localparam logic [32:0] B_GRB   = 33'd1 << 9;
    localparam logic [32:0] B_GRC   = 33'd1 << 8;
    localparam logic [32:0] B_RIN   = 33'd1 << 7;
    localparam logic [32:0] B_ROUT  = 33'd1 << 6;
    localparam logic [32:0] B_BA    = 33'd1 << 5;

    localparam logic [32:0] V_T0 = B_RUN | B_PCO | B_MAR;
    localparam logic [32:0] V_T1 = B_RUN | B_RD | B_MDR | B_INC | B_PCE;
    localparam logic [32:0] V_T2 = B_RUN | B_MDRO | B_IR;
    localparam logic [32:0] V_WB = B_RUN | B_ZLO | B_GRA | B_RIN;

    logic [32:0] ctl;
    assign ctl = {bus.Run, bus.PC_out, bus.ZHigh_out, bus.ZLow_out, bus.HI_out, bus.LO_out,
                  bus.C_out, bus.MDR_out, bus.in_port_out, bus.MAR_enable, bus.MDR_enable,
                  bus.IR_enable, bus.Y_enable, bus.Z_enable, bus.PC_enable, bus.HI_enable,
                  bus.LO_enable, bus.out_port_enable, bus.IncPC, bus.Read, bus.RAM_write_enable,
                  bus.con_in, bus.Gra, bus.Grb, bus.Grc, bus.R_in, bus.R_out, bus.BA_out, bus.opcode};

    int checks = 0;
    int errors = 0;
    int ram_pulses = 0;
    logic [32:0] exp_q[$];

    always @(negedge Clock)
        if (bus.RAM_write_enable === 1'b1) ram_pulses++;

    task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    // Called at the negedge of T0; checks every following step, then the next T0.
    task automatic run_instr(input string tag, input logic [4:0] op, input logic con);
        bus.IR     = {op, 27'h0};
        bus.CON_FF = con;
        for (int i = 0; i < exp_q.size(); i++) begin
            step();
            check($sformatf("%s_s%0d", tag, i + 1), ctl, exp_q[i]);
        end
        step();
        check({tag, "_next_t0"}, ctl, V_T0);
    endtask

    initial begin
        bus.IR     = 32'h0;
        bus.CON_FF = 1'b0;
        clr        = 1'b1;
        step();
        check("reset_c1", ctl, 33'd0);
        step();
        check("reset_c2", ctl, 33'd0);
        clr = 1'b0;
        step();
        check("first_t0", ctl, V_T0);

        exp_q = '{V_T1, V_T2, B_RUN | B_GRB | B_ROUT | B_Y, B_RUN | B_CO | B_Z | 33'h0D, V_WB};
        run_instr("andi", 5'b01101, 1'b0);

        exp_q = '{V_T1, V_T2, B_RUN | B_GRB | B_ROUT | B_Y, B_RUN | B_GRC | B_ROUT | B_Z | 33'h03, V_WB};
        run_instr("add", 5'b00011, 1'b0);

        exp_q = '{V_T1, V_T2, B_RUN | B_GRB | B_BA | B_Y, B_RUN | B_CO | B_Z | 33'h03,
                  B_RUN | B_ZLO | B_MAR, B_RUN | B_GRA | B_ROUT | B_MDR, B_RUN | B_WR};
        run_instr("st", 5'b00010, 1'b0);

        exp_q = '{V_T1, V_T2, B_RUN | B_GRB | B_BA | B_Y, B_RUN | B_CO | B_Z | 33'h03,
                  B_RUN | B_ZLO | B_MAR, B_RUN | B_RD | B_MDR, B_RUN | B_MDRO | B_GRA | B_RIN};
        run_instr("ld", 5'b00000, 1'b0);

        exp_q = '{V_T1, V_T2, B_RUN | B_GRB | B_BA | B_Y, B_RUN | B_CO | B_Z | 33'h03, V_WB};
        run_instr("ldi", 5'b00001, 1'b0);

        exp_q = '{V_T1, V_T2, B_RUN | B_GRA | B_ROUT | B_CON, B_RUN | B_PCO | B_Y,
                  B_RUN | B_CO | B_Z | 33'h03, B_RUN | B_ZLO};
        run_instr("br_con0", 5'b10011, 1'b0);
        exp_q[5] = B_RUN | B_ZLO | B_PCE;
        run_instr("br_con1", 5'b10011, 1'b1);

        exp_q = '{V_T1, V_T2, B_RUN | B_GRB | B_ROUT | B_Z | 33'h11, V_WB};
        run_instr("neg", 5'b10001, 1'b0);

        exp_q = '{V_T1, V_T2, B_RUN | B_HIO | B_GRA | B_RIN};
        run_instr("mfhi", 5'b11000, 1'b0);
        exp_q = '{V_T1, V_T2, B_RUN | B_GRA | B_ROUT | B_OUTP};
        run_instr("out", 5'b10111, 1'b0);
        exp_q = '{V_T1, V_T2, B_RUN};
        run_instr("undef", 5'b11111, 1'b0);

`ifdef CTRL_MULDIV_EN
        exp_q = '{V_T1, V_T2, B_RUN | B_GRA | B_ROUT | B_Y, B_RUN | B_GRB | B_ROUT | B_Z | 33'h10,
                  B_RUN | B_ZLO | B_LOE, B_RUN | B_ZHI | B_HIE};
`else
        exp_q = '{V_T1, V_T2, B_RUN};
`endif
        run_instr("mul", 5'b10000, 1'b0);

        // Second st, reset asserted during T6: the write in T7 must never happen.
        bus.IR = {5'b00010, 27'h0};
        exp_q = '{V_T1, V_T2, B_RUN | B_GRB | B_BA | B_Y, B_RUN | B_CO | B_Z | 33'h03,
                  B_RUN | B_ZLO | B_MAR, B_RUN | B_GRA | B_ROUT | B_MDR};
        for (int i = 0; i < exp_q.size(); i++) begin
            step();
            check($sformatf("st_abort_s%0d", i + 1), ctl, exp_q[i]);
        end
        clr = 1'b1;
        step();
        check("st_abort_reset", ctl, 33'd0);
        clr = 1'b0;
        step();
        check("st_abort_t0", ctl, V_T0);
        check("ram_write_pulses", 33'(ram_pulses), 33'd1);

        bus.IR = {5'b11011, 27'h0};
        exp_q = '{V_T1, V_T2, B_RUN};
        for (int i = 0; i < exp_q.size(); i++) begin
            step();
            check($sformatf("halt_s%0d", i + 1), ctl, exp_q[i]);
        end
        for (int i = 0; i < 20; i++) begin
            step();
            check($sformatf("halt_hold%0d", i), ctl, 33'd0);
        end
        clr = 1'b1;
        step();
        check("halt_reset", ctl, 33'd0);
        clr = 1'b0;
        step();
        check("halt_restart_t0", ctl, V_T0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hard-wired control unit for the Phase 2 CPU. It sits directly upstream of `DataPath` and drives every datapath control input that the integration benches currently sequence by hand. It runs a Moore-style step state machine (fetch T0–T2, execute T3–T7) and decodes `IR[31:27]` to pick the execute sequence. Its outputs connect one-to-one to the same-named `DataPath` ports.

## Interface
Parameters:
- `OP_ADD`, default 5'b00011, ALU opcode issued for address and branch-target adds.

Ports:
- `Clock`  in  1  system clock; all state changes on rising edge.
- `clr`  in  1  synchronous active-high reset.
- `IR`  in  32  instruction register contents from `DataPath`; opcode is `IR[31:27]`.
- `CON_FF`  in  1  branch condition flip-flop output.
- `Run`  out  1  1 while executing; 0 in reset and HALT.
- `PC_out`, `ZHigh_out`, `ZLow_out`, `HI_out`, `LO_out`, `C_out`, `MDR_out`, `in_port_out`  out  1 each  bus source selects.
- `MAR_enable`, `MDR_enable`, `IR_enable`, `Y_enable`, `Z_enable`, `PC_enable`, `HI_enable`, `LO_enable`, `out_port_enable`  out  1 each  register loads.
- `IncPC`, `Read`, `RAM_write_enable`, `con_in`  out  1 each  PC increment, memory read, memory write, CON load.
- `Gra`, `Grb`, `Grc`, `R_in`, `R_out`, `BA_out`  out  1 each  select-and-encode controls.
- `opcode`  out  5  ALU operation.

## Operation
- State register: RESET, T0–T7, HALT. Outputs are a combinational decode of the state and `IR`. No output depends combinationally on `CON_FF` except `PC_enable` in branch T6.
- Fetch (all instructions):
  - T0: `PC_out`, `MAR_enable`.
  - T1: `Read`, `MDR_enable`, `IncPC`, `PC_enable`.
  - T2: `MDR_out`, `IR_enable`.
- Execute begins at T3. The new `IR` value is valid from T3 onward.
- Register ALU ops (00011–01011): T3 `Grb`,`R_out`,`Y_enable`. T4 `Grc`,`R_out`,`opcode=IR[31:27]`,`Z_enable`. T5 `ZLow_out`,`Gra`,`R_in`.
- Immediate ALU ops (addi 01100, andi 01101, ori 01110): T3 `Grb`,`R_out`,`Y_enable`. T4 `C_out`,`opcode=IR[31:27]`,`Z_enable`. T5 `ZLow_out`,`Gra`,`R_in`.
- ldi (00001): T3 `Grb`,`BA_out`,`Y_enable`. T4 `C_out`,`opcode=OP_ADD`,`Z_enable`. T5 `ZLow_out`,`Gra`,`R_in`.
- ld (00000):
  - T3–T4 as ldi.
  - T5 `ZLow_out`,`MAR_enable`.
  - T6 `Read`,`MDR_enable`.
  - T7 `MDR_out`,`Gra`,`R_in`.
- st (00010):
  - T3–T5 as ld.
  - T6 `Gra`,`R_out`,`MDR_enable`, with `Read`=0.
  - T7 `RAM_write_enable`.
- neg/not (10001, 10010): T3 `Grb`,`R_out`,`opcode=IR[31:27]`,`Z_enable`. T4 `ZLow_out`,`Gra`,`R_in`.
- Branch (10011):
  - T3 `Gra`,`R_out`,`con_in`.
  - T4 `PC_out`,`Y_enable`.
  - T5 `C_out`,`opcode=OP_ADD`,`Z_enable`.
  - T6 `ZLow_out`, plus `PC_enable` only if `CON_FF`=1.
- mfhi/mflo (11000/11001): T3 `HI_out`/`LO_out`,`Gra`,`R_in`.
- in (10110): T3 `in_port_out`,`Gra`,`R_in`. out (10111): T3 `Gra`,`R_out`,`out_port_enable`.
- nop (11010) and any undefined opcode: T3 asserts nothing, then T0.
- halt (11011): T3 goes to HALT. HALT holds all outputs at 0 and `Run`=0 until `clr`.
- The last step of every sequence transitions to T0. `opcode` is 5'b00000 in every step not listed above.

## Timing
- One step per clock, with no wait states. Memory is single-cycle: read data is captured in the same step `Read` is asserted.
- Cycles per instruction, counted T0 to the next T0:
  - register/immediate ALU, ldi: 6
  - ld, st: 8
  - branch: 7
  - neg/not: 5
  - single-step ops, nop: 4
  - mul/div: 7
- `clr`=1 at any edge forces RESET, including mid-instruction or in HALT. In RESET every output is 0 and `Run`=0.
- The first edge with `clr`=0 moves RESET→T0, and `Run` becomes 1 from T0.
- A partially executed st is abandoned. Only a write already asserted in T7 before the reset edge has completed.
- `IR` changes during T2 are ignored. Decode samples `IR` only in T3–T7.

## Configuration
- `CTRL_MULDIV_EN` defined: mul (10000) and div (01111) execute as follows.
  - T3 `Gra`,`R_out`,`Y_enable`.
  - T4 `Grb`,`R_out`,`opcode=IR[31:27]`,`Z_enable`.
  - T5 `ZLow_out`,`LO_enable`.
  - T6 `ZHigh_out`,`HI_enable`.
- Undefined: 10000 and 01111 decode as nop (4 cycles), and `HI_enable`/`LO_enable` are never asserted by this path.

## Test plan
- `clr` high 2 cycles, then low → all outputs 0 and `Run`=0 during reset. T0 follows on the first low edge, with `PC_out`=`MAR_enable`=1.
- `IR`=andi (opcode 01101) → T4 asserts `C_out`,`Z_enable`,`opcode`=01101. T5 asserts `ZLow_out`,`Gra`,`R_in`. Next T0 is 6 cycles after the first.
- `IR`=st → T6 has `MDR_enable`=1 with `Read`=0, and T7 has `RAM_write_enable`=1. Assert `clr` during T6 of a second st: RESET follows and `RAM_write_enable` never pulses.
- Branch with `CON_FF`=0, then again with `CON_FF`=1 → `PC_enable` in T6 is 0, then 1. `con_in`=1 in T3 both times.
- `IR`=halt → `Run` falls after T3 and outputs stay 0 for 20 cycles. `clr` restarts fetch.
- `IR`=mul → with `CTRL_MULDIV_EN`: `LO_enable` in T5, `HI_enable` in T6. Without it: nop timing, with `HI_enable`/`LO_enable` never asserted.
